// File: rtl/vdrive_scaled.sv
// Scaled video driver: maps beam position to VRAM coordinates (64x32 x4 or 128x64 x2),
// vertically centres the image and colours pixels through a writable palette (3-clk latency).
module vdrive_scaled #(
    parameter int                  PLANES   = 2,
    parameter int                  RGB_BITS = 3,
    parameter int                  SCREEN_H = 240,
    parameter logic [RGB_BITS-1:0] BORDER   = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [8:0]          hpos,
    input  logic [8:0]          vpos,
    input  logic                display_on,
    input  logic                vsync,
    input  logic                hires_req,
    input  logic                pal_we,
    input  logic [PLANES-1:0]   pal_idx,
    input  logic [RGB_BITS-1:0] pal_data,
    output logic [6:0]          vram_hpos,
    output logic [5:0]          vram_vpos,
    input  logic [PLANES-1:0]   vram_pixel,
    output logic [RGB_BITS-1:0] rgb,
    output logic                hires,
    output logic                frame_tick
);

    localparam int          N_PAL = 2 ** PLANES;
    localparam logic [8:0]  TOP   = 9'((SCREEN_H - 128) / 2);
    localparam logic [8:0]  BOT   = 9'((SCREEN_H - 128) / 2 + 128);

    logic                in_win;
    logic [6:0]          col_hi;
    logic [5:0]          row_hi;
    logic                vsync_prev;
    logic                vsync_rise;
    logic                don_d1, don_d2;
    logic                win_d1, win_d2;
    logic [RGB_BITS-1:0] pal [N_PAL];

    assign in_win     = !hpos[8] && (vpos >= TOP) && (vpos < BOT);
    // Hires coordinates; lores simply drops one more LSB of each.
    assign col_hi     = 7'(hpos >> 1);
    assign row_hi     = 6'((vpos - TOP) >> 1);
    assign vsync_rise = vsync && !vsync_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            vram_hpos  <= '0;
            vram_vpos  <= '0;
            rgb        <= '0;
            hires      <= 1'b0;
            frame_tick <= 1'b0;
            vsync_prev <= 1'b0;
            don_d1     <= 1'b0;
            don_d2     <= 1'b0;
            win_d1     <= 1'b0;
            win_d2     <= 1'b0;
            for (int i = 0; i < N_PAL; i++) begin
                pal[i] <= RGB_BITS'(i);
            end
        end else begin
            // Mode only changes at frame start, so a frame is never drawn in mixed modes.
            vsync_prev <= vsync;
            frame_tick <= vsync_rise;
            if (vsync_rise) begin
                hires <= hires_req;
            end

            don_d1 <= display_on;
            win_d1 <= in_win;
            don_d2 <= don_d1;
            win_d2 <= win_d1;

            if (in_win) begin
                if (hires) begin
                    vram_hpos <= col_hi;
                    vram_vpos <= row_hi;
                end else begin
                    vram_hpos <= {1'b0, col_hi[6:1]};
                    vram_vpos <= {1'b0, row_hi[5:1]};
                end
            end

            // Palette read sees the pre-write value when both hit the same entry.
            rgb <= don_d2 ? (win_d2 ? pal[vram_pixel] : BORDER) : '0;

            if (pal_we) begin
                pal[pal_idx] <= pal_data;
            end
        end
    end

endmodule

// File: tb/tb_vdrive_scaled.sv
// Bench for vdrive_scaled: frame-level reference model checked every cycle,
// plus directed vectors with hand-computed values.
module tb_vdrive_scaled;

    localparam logic [2:0] BORDER_C = 3'b110;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] hpos, vpos;
    logic       display_on, vsync, hires_req, pal_we;
    logic [1:0] pal_idx;
    logic [2:0] pal_data;
    logic [6:0] vram_hpos;
    logic [5:0] vram_vpos;
    logic [1:0] vram_pixel;
    logic [2:0] rgb;
    logic       hires, frame_tick;

    vdrive_scaled #(
        .PLANES(2), .RGB_BITS(3), .SCREEN_H(240), .BORDER(BORDER_C)
    ) dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .display_on(display_on), .vsync(vsync), .hires_req(hires_req),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
        .vram_hpos(vram_hpos), .vram_vpos(vram_vpos), .vram_pixel(vram_pixel),
        .rgb(rgb), .hires(hires), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    logic [1:0] mem [128][64];
    always @(posedge clk) vram_pixel <= mem[vram_hpos][vram_vpos];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-beam-position colour from window rules, delayed by the pipeline.
    typedef struct {
        bit         don;
        bit         win;
        logic [1:0] pix;
    } ent_t;

    ent_t       h0 = '{0, 0, 2'd0};
    ent_t       h1 = '{0, 0, 2'd0};
    logic [2:0] pal_m [4];
    logic [2:0] exp_rgb   = 3'd0;
    bit         exp_hires = 1'b0;
    bit         exp_tick  = 1'b0;
    bit         vprev_m   = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            exp_rgb   = 3'd0;
            exp_hires = 1'b0;
            exp_tick  = 1'b0;
            vprev_m   = 1'b0;
            for (int i = 0; i < 4; i++) pal_m[i] = 3'(i);
            h0 = '{0, 0, 2'd0};
            h1 = '{0, 0, 2'd0};
        end else begin
            int   x, y, dy;
            ent_t e;
            exp_rgb = h1.don ? (h1.win ? pal_m[h1.pix] : BORDER_C) : 3'd0;
            e.don = display_on;
            e.win = (int'(hpos) < 256) && (int'(vpos) >= 56) && (int'(vpos) < 184);
            e.pix = 2'd0;
            if (e.win) begin
                dy = int'(vpos) - 56;
                x  = exp_hires ? int'(hpos) / 2 : int'(hpos) / 4;
                y  = exp_hires ? dy / 2 : dy / 4;
                e.pix = mem[x][y];
            end
            h1 = h0;
            h0 = e;
            if (pal_we) pal_m[pal_idx] = pal_data;
            exp_tick = vsync && !vprev_m;
            if (exp_tick) exp_hires = hires_req;
            vprev_m = vsync;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("rgb_model", rgb, exp_rgb);
            check("hires_model", hires, exp_hires);
            check("tick_model", frame_tick, exp_tick);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic beam(input int h, input int v, input bit d);
        hpos = 9'(h);
        vpos = 9'(v);
        display_on = d;
    endtask

    initial begin
        for (int x = 0; x < 128; x++)
            for (int y = 0; y < 64; y++)
                mem[x][y] = 2'((x + 2 * y + x / 5) % 4);
        mem[1][0] = 2'b10;
        mem[2][1] = 2'b01;
        mem[3][0] = 2'b11;

        reset = 1'b1; vsync = 1'b0; hires_req = 1'b0; pal_we = 1'b0;
        pal_idx = 2'd0; pal_data = 3'd0;
        beam(0, 0, 0);
        step(2);
        check("reset_rgb", rgb, 0);
        check("reset_vram_hpos", vram_hpos, 0);
        check("reset_vram_vpos", vram_vpos, 0);
        check("reset_hires", hires, 0);
        check("reset_tick", frame_tick, 0);

        // Lores address and 3-clk latency.
        reset = 1'b0;
        chk_en = 1'b1;
        beam(4, 56, 1);
        step(1);
        check("lores_vram_hpos", vram_hpos, 1);
        check("lores_vram_vpos", vram_vpos, 0);
        step(2);
        check("lores_rgb", rgb, 3'b010);

        // Switch to hires on vsync edge.
        vsync = 1'b1; hires_req = 1'b1;
        step(1);
        check("hires_on_edge", hires, 1);
        check("tick_high", frame_tick, 1);
        step(1);
        check("tick_single", frame_tick, 0);
        vsync = 1'b0;
        beam(255, 183, 1);
        step(1);
        check("hires_vram_hpos", vram_hpos, 127);
        check("hires_vram_vpos", vram_vpos, 63);
        step(2);

        // Mid-frame request is ignored until the next vsync rise.
        hires_req = 1'b0;
        step(5);
        check("hires_held", hires, 1);
        vsync = 1'b1;
        step(1);
        check("lores_on_edge", hires, 0);
        vsync = 1'b0;
        step(1);

        // Palette write then border and blank.
        pal_we = 1'b1; pal_idx = 2'd1; pal_data = 3'b101;
        beam(8, 60, 1);
        step(1);
        pal_we = 1'b0;
        step(2);
        check("pal_write_rgb", rgb, 3'b101);
        beam(8, 10, 1);
        step(3);
        check("border_v", rgb, BORDER_C);
        beam(300, 60, 1);
        step(3);
        check("border_h", rgb, BORDER_C);
        beam(8, 60, 0);
        step(3);
        check("blank", rgb, 0);

        // Reset mid-image in hires restores palette and mode.
        vsync = 1'b1; hires_req = 1'b1;
        step(1);
        vsync = 1'b0;
        pal_we = 1'b1; pal_idx = 2'd3; pal_data = 3'd0;
        beam(100, 100, 1);
        step(1);
        pal_we = 1'b0;
        step(3);
        reset = 1'b1;
        step(1);
        check("rst_mid_hires", hires, 0);
        check("rst_mid_rgb", rgb, 0);
        check("rst_mid_vram_hpos", vram_hpos, 0);
        reset = 1'b0; hires_req = 1'b0;
        beam(12, 56, 1);
        step(3);
        check("pal_restored", rgb, 3'b011);

        // Vsync already high as reset releases gives a tick.
        reset = 1'b1; vsync = 1'b1; hires_req = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
        check("tick_after_reset", frame_tick, 1);
        check("hires_after_reset", hires, 1);
        step(1);
        check("tick_after_reset_single", frame_tick, 0);
        vsync = 1'b0;
        step(1);

        // Frame sweeps: hires (every line) then lores (every other line).
        for (int mode = 1; mode >= 0; mode--) begin
            hires_req = mode[0];
            vsync = 1'b1;
            step(1);
            vsync = 1'b0;
            for (int v = 54; v <= 185; v += (mode == 1) ? 1 : 2) begin
                if (v == 120) hires_req = ~mode[0];
                for (int h = 0; h < 260; h++) begin
                    beam(h, v, h < 258);
                    pal_we = (h == 100) && (v % 3 == 0);
                    pal_idx = 2'(v % 4);
                    pal_data = 3'(v % 8);
                    step(1);
                end
            end
            pal_we = 1'b0;
            beam(0, 0, 0);
            step(3);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
